gpio_opb_if: RTL

OPB slave that conditions the hardware-interlock GPIO inputs (loop states, door switches, light-curtain, EMO) and drives the local loop-control outputs. Each input is synchronised to `OPB_CLK`, debounced on the shared `PULSE_2KHZ` tick, and edge-latched into sticky event bits with a masked interrupt. It sits between the board pins and the address decoder's GPIO slot: it consumes `GPIO_RE`/`GPIO_WE`/`OPB_ADDR`/write data and returns `GPIO_DO` on the decoder's `GPIO_IN` input.

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_debounce.sv | 57 +++++
 rtl/gpio_opb_if.sv | 87 ++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the interlock GPIO OPB slave: register indices and
// debounce counter width.
package gpio_pkg;
  localparam logic [2:0] GPIO_RAW    = 3'd0;
  localparam logic [2:0] GPIO_STATE  = 3'd1;
  localparam logic [2:0] GPIO_EVENT  = 3'd2;
  localparam logic [2:0] GPIO_MASK   = 3'd3;
  localparam logic [2:0] GPIO_OUTPUT = 3'd4;
  localparam logic [2:0] GPIO_INFO   = 3'd5;

  localparam int GPIO_DB_W = 4;
endpackage

// File: rtl/gpio_debounce.sv
// One conditioned input: 2-flop synchroniser, tick-driven debounce counter,
// debounced STATE bit and a combinational change pulse aligned with the STATE update.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic OPB_CLK,
  input  logic OPB_RST_N,
  input  logic PULSE_2KHZ,
  input  logic init,
  input  logic pin,
  output logic raw,
  output logic state,
  output logic change
);
  localparam logic [GPIO_DB_W-1:0] DB_LAST = GPIO_DB_W'(DB_TICKS - 1);

  logic [1:0]           sync_q;
  logic [GPIO_DB_W-1:0] cnt_q, cnt_d;
  logic                 state_q, state_d;

  assign raw    = sync_q[1];
  assign state  = state_q;
  // Change fires on the tick that accepts the new level so EVENT and STATE move together.
  assign change = PULSE_2KHZ && !init && (raw != state_q) && (cnt_q == DB_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (PULSE_2KHZ) begin
      if (init) begin
        state_d = raw;
        cnt_d   = '0;
      end else if (raw == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        state_d = raw;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pin};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/gpio_opb_if.sv
// OPB GPIO slot: per-pin debounce lanes, sticky W1C event register with mask,
// loop-control output register, registered read mux and interrupt.
module gpio_opb_if
  import gpio_pkg::*;
#(
  parameter int N_IN     = 16,
  parameter int DB_TICKS = 4,
  parameter int N_OUT    = 8
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RST_N,
  input  logic [31:0]      OPB_ADDR,
  input  logic [31:0]      GPIO_DI,
  input  logic             GPIO_RE,
  input  logic             GPIO_WE,
  output logic [31:0]      GPIO_DO,
  input  logic             PULSE_2KHZ,
  input  logic [N_IN-1:0]  GPIO_PIN,
  output logic [N_OUT-1:0] GPIO_OUT,
  output logic             GPIO_IRQ
);
  logic [N_IN-1:0]  raw, state, change;
  logic [N_IN-1:0]  event_q, event_d, mask_q;
  logic [N_OUT-1:0] out_q;
  logic [31:0]      do_q, rd_data;
  logic             init_done_q, irq_q;
  logic [2:0]       idx;
  logic             unused_bits;

  assign idx         = OPB_ADDR[4:2];
  assign unused_bits = ^{OPB_ADDR, GPIO_DI};

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    gpio_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .OPB_CLK    (OPB_CLK),
      .OPB_RST_N  (OPB_RST_N),
      .PULSE_2KHZ (PULSE_2KHZ),
      .init       (!init_done_q),
      .pin        (GPIO_PIN[i]),
      .raw        (raw[i]),
      .state      (state[i]),
      .change     (change[i])
    );
  end

  // A new event on the same bit outranks a simultaneous W1C.
  always_comb begin
    event_d = event_q;
    if (GPIO_WE && idx == GPIO_EVENT) event_d = event_q & ~GPIO_DI[N_IN-1:0];
    event_d = event_d | change;
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      GPIO_RAW:    rd_data = 32'(raw);
      GPIO_STATE:  rd_data = 32'(state);
      GPIO_EVENT:  rd_data = 32'(event_q);
      GPIO_MASK:   rd_data = 32'(mask_q);
      GPIO_OUTPUT: rd_data = 32'(out_q);
      GPIO_INFO:   rd_data = {8'(N_IN), 8'(N_OUT), 12'h0, 4'(DB_TICKS)};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      init_done_q <= 1'b0;
      event_q     <= '0;
      mask_q      <= '0;
      out_q       <= '0;
      do_q        <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (PULSE_2KHZ) init_done_q <= 1'b1;
      event_q <= event_d;
      irq_q   <= |(event_q & mask_q);
      if (GPIO_WE && idx == GPIO_MASK)   mask_q <= GPIO_DI[N_IN-1:0];
      if (GPIO_WE && idx == GPIO_OUTPUT) out_q  <= GPIO_DI[N_OUT-1:0];
      if (GPIO_RE) do_q <= rd_data;
    end
  end

  assign GPIO_DO  = do_q;
  assign GPIO_OUT = out_q;
  assign GPIO_IRQ = irq_q;
endmodule
